// File: rtl/div_share_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : div_share_scheduler_if
// Description : Bus to the shared external tens/ones divider.
//               div_in  - 6-bit binary operand (driven by the scheduler)
//               div_ten - 4-bit tens result   (combinational from div_in)
//               div_1   - 4-bit ones result   (combinational from div_in)
//               master modport : scheduler side
//               slave  modport : divider side
// Revision    : 1.0 - initial release
// ============================================================================
interface div_share_scheduler_if;
    logic [5:0] div_in;
    logic [3:0] div_ten;
    logic [3:0] div_1;

    modport master (output div_in, input div_ten, input div_1);
    modport slave  (input div_in, output div_ten, output div_1);
endinterface
`default_nettype wire

// File: rtl/div_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : div_share_scheduler
// Description : Time-shares one external tens/ones divider across the hours,
//               minutes and seconds values. The three values are snapshotted,
//               converted one per clock and all six BCD digits are committed
//               in a single edge. Also runs the 6-digit multiplexed display
//               scan, whose wrap requests a fresh conversion.
// Ports       : clk, rst_n          - clock, async active-low reset
//               refresh_req         - conversion request (level)
//               val_hr/min/sec      - binary time values
//               div (master)        - shared divider bus
//               bcd_digits          - {hr_t,hr_1,min_t,min_1,sec_t,sec_1}
//               upd_pulse           - one cycle when bcd_digits updates
//               busy                - conversion in progress
//               range_err           - {hr,min,sec} out-of-range of last commit
//               digit_sel/digit_bcd - active-low one-hot scan select + BCD
// Revision    : 1.0 - initial release
// ============================================================================
module div_share_scheduler #(
    parameter int SCAN_DIV = 1000,
    parameter int MAX_HR   = 24
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 refresh_req,
    input  wire logic [5:0]           val_hr,
    input  wire logic [5:0]           val_min,
    input  wire logic [5:0]           val_sec,
    div_share_scheduler_if.master     div,
    output logic      [23:0]          bcd_digits,
    output logic                      upd_pulse,
    output logic                      busy,
    output logic      [2:0]           range_err,
    output logic      [5:0]           digit_sel,
    output logic      [3:0]           digit_bcd
);

    localparam int c_cnt_w = $clog2(SCAN_DIV);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV_H = 3'd1,
        ST_CONV_M = 3'd2,
        ST_CONV_S = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_req;
    logic                 r_pending;
    logic                 r_auto_req;
    logic [5:0]           r_div_in;
    logic [5:0]           r_snap_hr;
    logic [5:0]           r_snap_min;
    logic [5:0]           r_snap_sec;
    logic [7:0]           r_stg_hr;
    logic [7:0]           r_stg_min;
    logic [7:0]           r_stg_sec;
    logic                 w_err_hr;
    logic                 w_err_min;
    logic                 w_err_sec;
    logic [c_cnt_w-1:0]   r_scan_cnt;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_next;
    logic                 w_scan_tc;
    logic [3:0]           w_nib;

    assign div.div_in = r_div_in;

    // Every request source collapses into one; a request arriving while
    // busy is remembered once in r_pending.
    assign w_req = refresh_req | r_auto_req | r_pending;

    // Range flags look at the snapshot so they match the committed digits.
    assign w_err_hr  = (r_snap_hr  >= 6'(MAX_HR));
    assign w_err_min = (r_snap_min >= 6'd60);
    assign w_err_sec = (r_snap_sec >= 6'd60);

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_req) begin
                    w_state_next = ST_CONV_H;
                end
            end
            ST_CONV_H: w_state_next = ST_CONV_M;
            ST_CONV_M: w_state_next = ST_CONV_S;
            ST_CONV_S: w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default: begin
                w_state_next = ST_IDLE;
                busy         = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot, divider sequencing, staging and commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_in   <= 6'd0;
            r_snap_hr  <= 6'd0;
            r_snap_min <= 6'd0;
            r_snap_sec <= 6'd0;
            r_stg_hr   <= 8'd0;
            r_stg_min  <= 8'd0;
            r_stg_sec  <= 8'd0;
            r_pending  <= 1'b0;
            bcd_digits <= 24'd0;
            range_err  <= 3'd0;
            upd_pulse  <= 1'b0;
        end else begin
            upd_pulse <= (r_state == ST_COMMIT);
            // IDLE always consumes whatever was pending.
            if (r_state == ST_IDLE) begin
                r_pending <= 1'b0;
            end else if (refresh_req || r_auto_req) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_snap_hr  <= val_hr;
                        r_snap_min <= val_min;
                        r_snap_sec <= val_sec;
                        r_div_in   <= val_hr;
                    end
                end
                ST_CONV_H: begin
                    r_stg_hr <= {div.div_ten, div.div_1};
                    r_div_in <= r_snap_min;
                end
                ST_CONV_M: begin
                    r_stg_min <= {div.div_ten, div.div_1};
                    r_div_in  <= r_snap_sec;
                end
                ST_CONV_S: begin
                    r_stg_sec <= {div.div_ten, div.div_1};
                    r_div_in  <= 6'd0;
                end
                ST_COMMIT: begin
                    bcd_digits <= {w_err_hr  ? 8'd0 : r_stg_hr,
                                   w_err_min ? 8'd0 : r_stg_min,
                                   w_err_sec ? 8'd0 : r_stg_sec};
                    range_err  <= {w_err_hr, w_err_min, w_err_sec};
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    assign w_scan_tc  = (r_scan_cnt == c_cnt_w'(SCAN_DIV - 1));
    assign w_idx_next = !w_scan_tc      ? r_idx :
                        (r_idx == 3'd5) ? 3'd0  : r_idx + 3'd1;

    always_comb begin
        w_nib = 4'd0;
        case (w_idx_next)
            3'd0: w_nib = bcd_digits[3:0];
            3'd1: w_nib = bcd_digits[7:4];
            3'd2: w_nib = bcd_digits[11:8];
            3'd3: w_nib = bcd_digits[15:12];
            3'd4: w_nib = bcd_digits[19:16];
            3'd5: w_nib = bcd_digits[23:20];
            default: w_nib = 4'd0;
        endcase
    end

    // digit_bcd is reloaded every clock from the digit that digit_sel will
    // show, so a commit reaches the display without waiting for a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
            r_auto_req <= 1'b0;
            digit_sel  <= 6'b111110;
            digit_bcd  <= 4'd0;
        end else begin
            r_scan_cnt <= w_scan_tc ? '0 : r_scan_cnt + c_cnt_w'(1);
            r_idx      <= w_idx_next;
            r_auto_req <= w_scan_tc && (r_idx == 3'd5);
            digit_sel  <= ~(6'b000001 << w_idx_next);
            digit_bcd  <= w_nib;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_share_scheduler
// Description : Directed self-checking bench. Instance A uses the default
//               scan divider for the conversion tests; instance B uses
//               SCAN_DIV=4 to exercise the display scan. Both share clock,
//               reset and value inputs; each has a behavioural divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_share_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refresh_a;
    logic        refresh_b;
    logic [5:0]  val_hr;
    logic [5:0]  val_min;
    logic [5:0]  val_sec;

    logic [23:0] bcd_a, bcd_b;
    logic        upd_a, upd_b;
    logic        busy_a, busy_b;
    logic [2:0]  rerr_a, rerr_b;
    logic [5:0]  sel_a, sel_b;
    logic [3:0]  dbcd_a, dbcd_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_share_scheduler_if dif_a ();
    div_share_scheduler_if dif_b ();

    assign dif_a.div_ten = 4'(dif_a.div_in / 6'd10);
    assign dif_a.div_1   = 4'(dif_a.div_in % 6'd10);
    assign dif_b.div_ten = 4'(dif_b.div_in / 6'd10);
    assign dif_b.div_1   = 4'(dif_b.div_in % 6'd10);

    div_share_scheduler #(.SCAN_DIV(1000), .MAX_HR(24)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .refresh_req(refresh_a),
        .val_hr(val_hr), .val_min(val_min), .val_sec(val_sec),
        .div(dif_a), .bcd_digits(bcd_a), .upd_pulse(upd_a), .busy(busy_a),
        .range_err(rerr_a), .digit_sel(sel_a), .digit_bcd(dbcd_a)
    );

    div_share_scheduler #(.SCAN_DIV(4), .MAX_HR(24)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .refresh_req(refresh_b),
        .val_hr(val_hr), .val_min(val_min), .val_sec(val_sec),
        .div(dif_b), .bcd_digits(bcd_b), .upd_pulse(upd_b), .busy(busy_b),
        .range_err(rerr_b), .digit_sel(sel_b), .digit_bcd(dbcd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_vals(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        val_hr  = h;
        val_min = m;
        val_sec = s;
    endtask

    // Request a conversion on A and return just after the commit edge.
    task automatic convert_a(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        set_vals(h, m, s);
        refresh_a = 1'b1;
        tick();
        refresh_a = 1'b0;
        ticks(4);
    endtask

    initial begin
        logic [23:0] ref_b;
        logic [5:0]  exp_sel;

        rst_n     = 1'b0;
        refresh_a = 1'b0;
        refresh_b = 1'b0;
        set_vals(6'd0, 6'd0, 6'd0);

        // ---------------- reset state ----------------
        ticks(2);
        chk("rst_bcd",      32'(bcd_a),        32'h0);
        chk("rst_sel",      32'(sel_a),        32'h3E);
        chk("rst_busy",     32'(busy_a),       32'h0);
        chk("rst_div_in",   32'(dif_a.div_in), 32'h0);
        chk("rst_upd",      32'(upd_a),        32'h0);
        chk("rst_rerr",     32'(rerr_a),       32'h0);
        chk("rst_dbcd",     32'(dbcd_a),       32'h0);
        chk("rst_sel_b",    32'(sel_b),        32'h3E);

        // ---------------- scan on B (SCAN_DIV=4) ----------------
        rst_n = 1'b1;
        set_vals(6'd12, 6'd34, 6'd56);
        ref_b = 24'h123456;
        refresh_b = 1'b1;
        tick();                                 // e1
        refresh_b = 1'b0;
        ticks(4);                               // e5: commit
        chk("scan_bcd",     32'(bcd_b),        32'h123456);
        chk("scan_upd",     32'(upd_b),        32'h1);
        for (int k = 2; k <= 5; k++) begin
            ticks(k == 2 ? 3 : 4);              // e8, e12, e16, e20
            exp_sel = ~(6'b000001 << k);
            chk("scan_sel",  32'(sel_b),  32'(exp_sel));
            chk("scan_dbcd", 32'(dbcd_b), 32'(ref_b[k*4 +: 4]));
        end
        chk("scan_busy_pre", 32'(busy_b),      32'h0);
        ticks(3);                               // e23
        chk("scan_hold",    32'(sel_b),        32'h1F);
        tick();                                 // e24: wrap
        chk("scan_wrap_sel",  32'(sel_b),      32'h3E);
        chk("scan_wrap_dbcd", 32'(dbcd_b),     32'h6);
        chk("scan_wrap_busy", 32'(busy_b),     32'h0);
        tick();                                 // e25: auto conversion starts
        chk("scan_auto_busy", 32'(busy_b),     32'h1);
        ticks(3);                               // e28
        chk("scan_sel1",    32'(sel_b),        32'h3D);
        chk("scan_dbcd1",   32'(dbcd_b),       32'h5);
        tick();                                 // e29: auto commit
        chk("scan_auto_upd", 32'(upd_b),       32'h1);

        // ---------------- basic conversion on A ----------------
        set_vals(6'd23, 6'd45, 6'd7);
        refresh_a = 1'b1;
        tick();                                 // t
        refresh_a = 1'b0;
        chk("conv_div_hr",  32'(dif_a.div_in), 32'd23);
        chk("conv_busy",    32'(busy_a),       32'h1);
        set_vals(6'd11, 6'd11, 6'd11);          // must not leak in
        tick();
        chk("conv_div_min", 32'(dif_a.div_in), 32'd45);
        tick();
        chk("conv_div_sec", 32'(dif_a.div_in), 32'd7);
        tick();                                 // t+3
        chk("conv_div_0",   32'(dif_a.div_in), 32'd0);
        chk("conv_busy3",   32'(busy_a),       32'h1);
        chk("conv_noupd",   32'(upd_a),        32'h0);
        tick();                                 // t+4
        chk("conv_bcd",     32'(bcd_a),        32'h234507);
        chk("conv_upd",     32'(upd_a),        32'h1);
        chk("conv_rerr",    32'(rerr_a),       32'h0);
        chk("conv_idle",    32'(busy_a),       32'h0);
        tick();
        chk("conv_upd_off", 32'(upd_a),        32'h0);

        // ---------------- pending request ----------------
        set_vals(6'd12, 6'd34, 6'd56);
        refresh_a = 1'b1;
        tick();                                 // t
        refresh_a = 1'b0;
        tick();                                 // t+1
        refresh_a = 1'b1;
        tick();                                 // t+2: busy -> pending
        refresh_a = 1'b0;
        set_vals(6'd8, 6'd9, 6'd10);
        ticks(2);                               // t+4
        chk("pend_bcd1",    32'(bcd_a),        32'h123456);
        chk("pend_upd1",    32'(upd_a),        32'h1);
        tick();                                 // t+5
        chk("pend_upd_off", 32'(upd_a),        32'h0);
        chk("pend_busy",    32'(busy_a),       32'h1);
        chk("pend_div_hr",  32'(dif_a.div_in), 32'd8);
        ticks(3);                               // t+8
        chk("pend_noupd",   32'(upd_a),        32'h0);
        tick();                                 // t+9
        chk("pend_bcd2",    32'(bcd_a),        32'h080910);
        chk("pend_upd2",    32'(upd_a),        32'h1);
        tick();
        chk("pend_done_upd",  32'(upd_a),      32'h0);
        chk("pend_done_busy", 32'(busy_a),     32'h0);

        // ---------------- range checks ----------------
        convert_a(6'd30, 6'd60, 6'd59);
        chk("rng1_bcd",  32'(bcd_a),  32'h000059);
        chk("rng1_rerr", 32'(rerr_a), 32'h6);
        convert_a(6'd23, 6'd59, 6'd59);
        chk("rng2_bcd",  32'(bcd_a),  32'h235959);
        chk("rng2_rerr", 32'(rerr_a), 32'h0);
        convert_a(6'd24, 6'd0, 6'd0);
        chk("rng3_bcd",  32'(bcd_a),  32'h000000);
        chk("rng3_rerr", 32'(rerr_a), 32'h4);
        convert_a(6'd63, 6'd63, 6'd63);
        chk("rng4_bcd",  32'(bcd_a),  32'h000000);
        chk("rng4_rerr", 32'(rerr_a), 32'h7);
        convert_a(6'd5, 6'd59, 6'd60);
        chk("rng5_bcd",  32'(bcd_a),  32'h055900);
        chk("rng5_rerr", 32'(rerr_a), 32'h1);
        chk("rng5_upd",  32'(upd_a),  32'h1);

        // ---------------- reset during CONV_M ----------------
        tick();
        set_vals(6'd1, 6'd2, 6'd3);
        refresh_a = 1'b1;
        tick();                                 // t: CONV_H
        refresh_a = 1'b0;
        tick();                                 // t+1: CONV_M
        rst_n = 1'b0;
        #1;
        chk("arst_bcd",    32'(bcd_a),        32'h0);
        chk("arst_busy",   32'(busy_a),       32'h0);
        chk("arst_div_in", 32'(dif_a.div_in), 32'h0);
        chk("arst_rerr",   32'(rerr_a),       32'h0);
        chk("arst_sel",    32'(sel_a),        32'h3E);
        chk("arst_bcd_b",  32'(bcd_b),        32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_noupd", 32'(upd_a), 32'h0);
        end
        rst_n = 1'b1;
        tick();
        chk("arst_idle",   32'(busy_a),       32'h0);
        convert_a(6'd11, 6'd22, 6'd33);
        chk("arst_bcd2",   32'(bcd_a),        32'h112233);
        chk("arst_upd2",   32'(upd_a),        32'h1);
        chk("arst_rerr2",  32'(rerr_a),       32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
